// File: rtl/ram_scan_reader_pkg.sv
// Shared types and defaults for the RAM scan reader.
// State encoding of the scan FSM plus default geometry of the 32x4 RAM.
// Imported by the top and by the dwell counter.
package ram_scan_reader_pkg;

  // Default RAM geometry used by the RAM/display top.
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 4;

  // Scan FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_e;

  // Width of a counter able to hold the value DWELL-1 (never below 1 bit).
  function automatic int unsigned dwell_cnt_w(input int unsigned dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/ram_scan_reader_dwell.sv
// Loadable down-counter that times how long a captured word is held.
// Latency: load/decrement visible one cycle after the edge; zero flag is combinational.
// Backpressure: hold_i freezes the count; clear_i beats load_i beats decrement.
module scan_dwell_counter
  import ram_scan_reader_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             hold_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, then load, then a decrement that stops at zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && !hold_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/ram_scan_reader.sv
// Sweeps the 32x4 RAM and presents each captured word with its address.
// Latency: first rd_valid 2 cycles after the start edge, then one capture every DWELL+2 cycles.
// Backpressure: wr_en owns the RAM port and stalls the scan in ISSUE; pause freezes HOLD.
module ram_scan_reader
  import ram_scan_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DWELL      = 2,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       CNT_W      = dwell_cnt_w(DWELL);
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  scan_state_e       state_q;
  logic [ADDR_W-1:0] scan_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              busy_q;
  logic              done_q;

  logic              dwell_load;
  logic              dwell_dec;
  logic              dwell_zero;

  // The user write path always owns the RAM port; the scan address is only
  // presented when no write is pending.
  assign ram_address = wr_en ? wr_address : scan_addr_q;
  assign ram_wren    = wr_en;
  assign ram_data    = wr_data;

  // Dwell is armed on the capture cycle and counted down only in HOLD.
  // stop clears it so an aborted sweep never leaves a stale count behind.
  assign dwell_load = (state_q == ST_CAPTURE);
  assign dwell_dec  = (state_q == ST_HOLD);

  scan_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clock_i    (clock),
    .resetn_i   (resetn),
    .clear_i    (stop),
    .load_i     (dwell_load),
    .load_val_i (DWELL_LOAD),
    .dec_i      (dwell_dec),
    .hold_i     (pause),
    .zero_o     (dwell_zero)
  );

  // Scan FSM with address counter and registered read-side outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      scan_addr_q <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a capture in flight and start.
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state_q     <= ST_ISSUE;
              scan_addr_q <= '0;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
            end
          end
          ST_ISSUE: begin
            // The RAM latches scan_addr on the edge that leaves ISSUE, so only
            // leave when the write path is not using the port.
            if (!wr_en) begin
              state_q <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            // ram_q now reflects scan_addr; a write arriving this cycle only
            // changes the address latched for the next read.
            rd_data_q  <= ram_q;
            rd_addr_q  <= scan_addr_q;
            rd_valid_q <= 1'b1;
            state_q    <= ST_HOLD;
          end
          ST_HOLD: begin
            if (!pause && dwell_zero) begin
              if (scan_addr_q != LAST_ADDR) begin
                scan_addr_q <= scan_addr_q + 1'b1;
                state_q     <= ST_ISSUE;
              end else if (CONTINUOUS != 0) begin
                scan_addr_q <= '0;
                state_q     <= ST_ISSUE;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader: single-sweep and continuous instances, each
// attached to a 32x4 RAM with a registered read address.
module tb_ram_scan_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- single-sweep instance (a_) ----------------
  logic       a_rstn, a_start, a_stop, a_pause, a_wr_en;
  logic [4:0] a_wr_address, a_ram_address, a_rd_addr;
  logic [3:0] a_wr_data, a_ram_data, a_ram_q, a_rd_data;
  logic       a_ram_wren, a_rd_valid, a_busy, a_done;

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .DWELL(2), .CONTINUOUS(0)) u_dut (
    .clock(clk), .resetn(a_rstn), .start(a_start), .stop(a_stop), .pause(a_pause),
    .wr_en(a_wr_en), .wr_address(a_wr_address), .wr_data(a_wr_data),
    .ram_address(a_ram_address), .ram_wren(a_ram_wren), .ram_data(a_ram_data),
    .ram_q(a_ram_q), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .busy(a_busy), .done(a_done)
  );

  // ---------------- continuous instance (c_) ----------------
  logic       c_rstn, c_start, c_stop, c_pause, c_wr_en;
  logic [4:0] c_wr_address, c_ram_address, c_rd_addr;
  logic [3:0] c_wr_data, c_ram_data, c_ram_q, c_rd_data;
  logic       c_ram_wren, c_rd_valid, c_busy, c_done;

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .DWELL(2), .CONTINUOUS(1)) u_cont (
    .clock(clk), .resetn(c_rstn), .start(c_start), .stop(c_stop), .pause(c_pause),
    .wr_en(c_wr_en), .wr_address(c_wr_address), .wr_data(c_wr_data),
    .ram_address(c_ram_address), .ram_wren(c_ram_wren), .ram_data(c_ram_data),
    .ram_q(c_ram_q), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid),
    .busy(c_busy), .done(c_done)
  );

  // ---------------- RAM models: registered address, read data one cycle later ----
  logic [3:0] mem_a [32];
  logic [3:0] mem_c [32];
  logic [4:0] raddr_a, raddr_c;
  always @(posedge clk) begin
    if (a_ram_wren) mem_a[a_ram_address] <= a_ram_data;
    raddr_a <= a_ram_address;
    if (c_ram_wren) mem_c[c_ram_address] <= c_ram_data;
    raddr_c <= c_ram_address;
  end
  assign a_ram_q = mem_a[raddr_a];
  assign c_ram_q = mem_c[raddr_c];

  // What the bench has written into each RAM.
  logic [3:0] exp_a [32];
  logic [3:0] exp_c [32];

  // Capture logs (cycle, address, data) of every rd_valid pulse.
  int         qa_cyc[$];
  logic [4:0] qa_addr[$];
  logic [3:0] qa_data[$];
  int         qc_cyc[$];
  logic [4:0] qc_addr[$];
  logic [3:0] qc_data[$];

  always @(negedge clk) begin
    if (a_rd_valid === 1'b1) begin
      qa_cyc.push_back(cyc); qa_addr.push_back(a_rd_addr); qa_data.push_back(a_rd_data);
    end
    if (c_rd_valid === 1'b1) begin
      qc_cyc.push_back(cyc); qc_addr.push_back(c_rd_addr); qc_data.push_back(c_rd_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void clear_a();
    qa_cyc.delete(); qa_addr.delete(); qa_data.delete();
  endfunction

  // One full single-sweep run on the a_ instance. Pause is applied on the
  // first HOLD cycle of address p_at for p_len cycles; a write is held for
  // w_len cycles while the scan sits in ISSUE for address w_at.
  // Expected capture k lands at s+3+4k plus whichever stalls precede it.
  task automatic sweep_a(input int p_at, input int p_len, input int w_at, input int w_len,
                         input string tag);
    int s, p0, w0, done_cyc, n, ecyc, last_cyc, wa;
    logic [3:0] wd;
    bit got_done;
    clear_a();
    wa = w_at + $urandom_range(0, 31 - w_at);
    wd = 4'($urandom);
    got_done = 0;
    done_cyc = 0;
    last_cyc = 0;
    @(posedge clk); #1;
    s = cyc;
    a_start = 1'b1;
    p0 = s + 3 + 4 * p_at + ((w_at <= p_at) ? w_len : 0);
    w0 = s + 1 + 4 * w_at + ((p_at < w_at) ? p_len : 0);
    for (int i = 0; i < 600 && !got_done; i++) begin
      @(posedge clk); #1;
      a_start      = 1'b0;
      a_pause      = (p_len > 0) && (cyc >= p0) && (cyc < p0 + p_len);
      a_wr_en      = (w_len > 0) && (cyc >= w0) && (cyc < w0 + w_len);
      a_wr_address = 5'(wa);
      a_wr_data    = wd;
      if (a_wr_en) begin
        exp_a[wa] = wd;
        #1;
        check({tag, "_ram_wren"}, 32'(a_ram_wren), 1);
        check({tag, "_ram_addr_mux"}, 32'(a_ram_address), 32'(wa));
      end
      if (a_done === 1'b1) begin
        got_done = 1;
        done_cyc = cyc;
      end
    end
    a_pause = 1'b0;
    a_wr_en = 1'b0;
    check({tag, "_done_reached"}, 32'(got_done), 1);
    n = qa_cyc.size();
    check({tag, "_n_captures"}, n, 32);
    for (int k = 0; k < n && k < 32; k++) begin
      ecyc = s + 3 + 4 * k + ((k > p_at) ? p_len : 0) + ((k >= w_at) ? w_len : 0);
      check($sformatf("%s_addr%0d", tag, k), 32'(qa_addr[k]), k);
      check($sformatf("%s_data%0d", tag, k), 32'(qa_data[k]), 32'(exp_a[k]));
      check($sformatf("%s_cyc%0d", tag, k), qa_cyc[k], ecyc);
      last_cyc = ecyc;
    end
    if (got_done) begin
      check({tag, "_done_time"}, done_cyc, last_cyc + 2);
      check({tag, "_busy_after_done"}, 32'(a_busy), 0);
    end
  endtask

  initial begin
    int s, r, m, n, dh;
    a_rstn = 0; a_start = 0; a_stop = 0; a_pause = 0; a_wr_en = 0; a_wr_address = 0; a_wr_data = 0;
    c_rstn = 0; c_start = 0; c_stop = 0; c_pause = 0; c_wr_en = 0; c_wr_address = 0; c_wr_data = 0;
    repeat (3) @(posedge clk);
    #1;
    a_rstn = 1; c_rstn = 1;

    // Reset state.
    @(negedge clk);
    check("rst_rd_addr", 32'(a_rd_addr), 0);
    check("rst_rd_data", 32'(a_rd_data), 0);
    check("rst_rd_valid", 32'(a_rd_valid), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);

    // Preload through the write path: pattern for a_, random for c_.
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      a_wr_en = 1; a_wr_address = 5'(k); a_wr_data = 4'(k) ^ 4'hA;
      c_wr_en = 1; c_wr_address = 5'(k); c_wr_data = 4'($urandom);
      exp_a[k] = 4'(k) ^ 4'hA;
      exp_c[k] = c_wr_data;
      #1;
      if (k == 0 || k == 31) begin
        check($sformatf("pre_wren%0d", k), 32'(a_ram_wren), 1);
        check($sformatf("pre_addr%0d", k), 32'(a_ram_address), k);
        check($sformatf("pre_data%0d", k), 32'(a_ram_data), 32'(exp_a[k]));
      end
    end
    @(posedge clk); #1;
    a_wr_en = 0; c_wr_en = 0;
    #1;
    check("idle_wren", 32'(a_ram_wren), 0);
    check("idle_scan_addr", 32'(a_ram_address), 0);

    // 1: plain sweep.
    sweep_a(0, 0, 0, 0, "t1");

    // 2+3: pause 10 cycles in HOLD at addr 5, write held 3 cycles in ISSUE at addr 7.
    sweep_a(5, 10, 7, 3, "t23");

    // Randomised stall placement.
    sweep_a($urandom_range(0, 30), $urandom_range(1, 8), $urandom_range(0, 31),
            $urandom_range(1, 5), "trnd");

    // 5: stop around addr 12, with a write in progress.
    clear_a();
    @(posedge clk); #1;
    a_start = 1;
    @(posedge clk); #1;
    a_start = 0;
    for (int i = 0; i < 200 && qa_addr.size() < 13; i++) begin
      @(posedge clk); #1;
    end
    check("t5_reach12", qa_addr.size(), 13);
    r = $urandom_range(0, 2);
    repeat (r) begin
      @(posedge clk); #1;
    end
    a_stop = 1; a_wr_en = 1; a_wr_address = 5'd3; a_wr_data = exp_a[3];
    @(posedge clk); #1;
    a_stop = 0; a_wr_en = 0;
    check("t5_busy", 32'(a_busy), 0);
    check("t5_done", 32'(a_done), 0);
    check("t5_rd_addr", 32'(a_rd_addr), 12);
    check("t5_rd_data", 32'(a_rd_data), 32'(exp_a[12]));
    repeat (12) @(posedge clk);
    #1;
    check("t5_no_more_valid", qa_addr.size(), 13);
    check("t5_rd_addr_kept", 32'(a_rd_addr), 12);

    // Restart after stop begins at addr 0.
    clear_a();
    m = $urandom_range(1, 20);
    s = cyc;
    a_start = 1;
    @(posedge clk); #1;
    a_start = 0;
    for (int i = 0; i < 200 && qa_addr.size() < m + 1; i++) begin
      @(posedge clk); #1;
    end
    n = qa_addr.size();
    check("t5_restart_n", n, m + 1);
    if (n > 0) begin
      check("t5_restart_addr0", 32'(qa_addr[0]), 0);
      check("t5_restart_cyc0", qa_cyc[0], s + 3);
    end

    // 6: reset for one cycle mid-HOLD.
    a_rstn = 0;
    @(posedge clk); #1;
    a_rstn = 1;
    check("t6_rd_addr", 32'(a_rd_addr), 0);
    check("t6_rd_data", 32'(a_rd_data), 0);
    check("t6_rd_valid", 32'(a_rd_valid), 0);
    check("t6_busy", 32'(a_busy), 0);
    check("t6_done", 32'(a_done), 0);

    // start held high: one sweep begins, later start levels are ignored.
    clear_a();
    s = cyc;
    a_start = 1;
    repeat (40) @(posedge clk);
    #1;
    n = qa_addr.size();
    check("t6_n_captures", n, 10);
    for (int k = 0; k < n && k < 8; k++) begin
      check($sformatf("t6_addr%0d", k), 32'(qa_addr[k]), k);
      check($sformatf("t6_cyc%0d", k), qa_cyc[k], s + 3 + 4 * k);
    end
    a_start = 0;
    a_stop = 1;
    @(posedge clk); #1;
    a_stop = 0;

    // 4: continuous mode over three-plus sweeps.
    qc_cyc.delete(); qc_addr.delete(); qc_data.delete();
    dh = 0;
    s = cyc;
    c_start = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      c_start = 0;
      if (c_done !== 1'b0) dh++;
    end
    check("t4_done_low", dh, 0);
    check("t4_busy", 32'(c_busy), 1);
    n = qc_addr.size();
    check("t4_n_captures", n, 100);
    if (n > 32) check("t4_wrap_to_0", 32'(qc_addr[32]), 0);
    for (int k = 0; k < n && k < 100; k++) begin
      check($sformatf("t4_addr%0d", k), 32'(qc_addr[k]), k % 32);
      check($sformatf("t4_data%0d", k), 32'(qc_data[k]), 32'(exp_c[k % 32]));
      check($sformatf("t4_cyc%0d", k), qc_cyc[k], s + 3 + 4 * k);
    end
    c_stop = 1;
    @(posedge clk); #1;
    c_stop = 0;
    #1;
    check("t4_stop_busy", 32'(c_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
